// File: rtl/cw_detector.sv
// cw_detector -- receive-side CW keying recovery.
//
// Smooths received tone magnitude samples with a first-order IIR filter. It
// applies on/off thresholds with hysteresis to the filtered value, and
// debounces the result into an active-low key line. Each completed mark or
// space element is reported with its length in valid samples.
//
// Ports:
//   i_clk            system clock
//   i_resetn         asynchronous active-low reset (release synchronous to i_clk)
//   i_valid          sample strobe, may be high every cycle
//   iS_magnitude     signed magnitude sample (negative values clamp to 0)
//   i_thresholdOn    unsigned; average >= this is a mark candidate (space side)
//   i_thresholdOff   unsigned; average <  this is a space candidate (mark side)
//   oS_average       filtered magnitude, always >= 0
//   o_key_n          recovered key, 0 = mark, 1 = space
//   o_durationValid  one-cycle pulse when an element completes
//   o_durationMark   1 = completed element was a mark
//   o_duration       completed element length in valid samples (saturating)
module cw_detector #(
  parameter int DATA_WIDTH  = 16,
  parameter int AVG_SHIFT   = 4,
  parameter int DEBOUNCE    = 8,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic                          i_valid,
  input  logic signed [DATA_WIDTH-1:0]  iS_magnitude,
  input  logic        [DATA_WIDTH-1:0]  i_thresholdOn,
  input  logic        [DATA_WIDTH-1:0]  i_thresholdOff,
  output logic signed [DATA_WIDTH-1:0]  oS_average,
  output logic                          o_key_n,
  output logic                          o_durationValid,
  output logic                          o_durationMark,
  output logic        [COUNT_WIDTH-1:0] o_duration
);

  localparam int ACC_WIDTH = DATA_WIDTH + AVG_SHIFT;
  localparam int DEB_WIDTH = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SPACE      = 2'd0,
    ST_MARK_PEND  = 2'd1,
    ST_MARK       = 2'd2,
    ST_SPACE_PEND = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // IIR filter: acc <= acc + mag - (acc >> AVG_SHIFT); average = acc >> AVG_SHIFT.
  // The accumulator can never go negative because acc >> AVG_SHIFT <= acc, and
  // its steady state for a clamped sample is at most (2^(DATA_WIDTH-1)-1) <<
  // AVG_SHIFT, so it fits in ACC_WIDTH bits.
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  mag_ext;
  logic [DATA_WIDTH-1:0] avg_u;

  always_comb begin
    mag_ext = '0;
    if (!iS_magnitude[DATA_WIDTH-1]) begin
      mag_ext = {{AVG_SHIFT{1'b0}}, iS_magnitude};
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (i_valid) begin
      acc_d = acc_q + mag_ext - (acc_q >> AVG_SHIFT);
    end
  end

  assign avg_u      = acc_q[ACC_WIDTH-1 -: DATA_WIDTH];
  assign oS_average = $signed(avg_u);

  // ---------------------------------------------------------------------------
  // Decision pipeline: the FSM evaluates the average one edge after the sample
  // that produced it, gated by the delayed strobe.
  // ---------------------------------------------------------------------------
  logic                   eval_q;
  state_t                 state_q, state_d;
  logic [DEB_WIDTH-1:0]   deb_q, deb_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [COUNT_WIDTH-1:0] dur_q, dur_d;
  logic                   dur_mark_q, dur_mark_d;
  logic                   dur_valid_q, dur_valid_d;
  logic                   cand_mark, cand_space;
  logic                   commit_mark, commit_space;

  assign cand_mark  = (avg_u >= i_thresholdOn);
  assign cand_space = (avg_u <  i_thresholdOff);

  // The element counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    cnt_d        = cnt_q;
    dur_d        = dur_q;
    dur_mark_d   = dur_mark_q;
    dur_valid_d  = 1'b0;
    commit_mark  = 1'b0;
    commit_space = 1'b0;

    if (eval_q) begin
      // Pending samples still belong to the element being left, so every
      // evaluated sample is counted, including the committing one.
      cnt_d = cnt_inc;

      unique case (state_q)
        ST_SPACE: begin
          if (cand_mark) begin
            if (DEBOUNCE == 1) begin
              commit_mark = 1'b1;
            end else begin
              state_d = ST_MARK_PEND;
              deb_d   = DEB_WIDTH'(1);
            end
          end
        end
        ST_MARK_PEND: begin
          if (cand_mark) begin
            if (deb_q == DEB_WIDTH'(DEBOUNCE - 1)) begin
              commit_mark = 1'b1;
            end else begin
              deb_d = deb_q + DEB_WIDTH'(1);
            end
          end else begin
            state_d = ST_SPACE;
            deb_d   = '0;
          end
        end
        ST_MARK: begin
          if (cand_space) begin
            if (DEBOUNCE == 1) begin
              commit_space = 1'b1;
            end else begin
              state_d = ST_SPACE_PEND;
              deb_d   = DEB_WIDTH'(1);
            end
          end
        end
        ST_SPACE_PEND: begin
          if (cand_space) begin
            if (deb_q == DEB_WIDTH'(DEBOUNCE - 1)) begin
              commit_space = 1'b1;
            end else begin
              deb_d = deb_q + DEB_WIDTH'(1);
            end
          end else begin
            state_d = ST_MARK;
            deb_d   = '0;
          end
        end
        default: begin
          state_d = ST_SPACE;
          deb_d   = '0;
        end
      endcase

      if (commit_mark || commit_space) begin
        state_d     = commit_mark ? ST_MARK : ST_SPACE;
        deb_d       = '0;
        dur_d       = cnt_inc;
        cnt_d       = '0;
        dur_valid_d = 1'b1;
        // A commit to space means a mark just ended, and vice versa.
        dur_mark_d  = commit_space;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      acc_q       <= '0;
      eval_q      <= 1'b0;
      state_q     <= ST_SPACE;
      deb_q       <= '0;
      cnt_q       <= '0;
      dur_q       <= '0;
      dur_mark_q  <= 1'b0;
      dur_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      eval_q      <= i_valid;
      state_q     <= state_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      dur_q       <= dur_d;
      dur_mark_q  <= dur_mark_d;
      dur_valid_q <= dur_valid_d;
    end
  end

  // Key is low for the committed mark and while a space is still pending.
  assign o_key_n         = !((state_q == ST_MARK) || (state_q == ST_SPACE_PEND));
  assign o_durationValid = dur_valid_q;
  assign o_durationMark  = dur_mark_q;
  assign o_duration      = dur_q;

endmodule

// File: tb/tb_cw_detector.sv
// Self-checking bench for cw_detector. Three instances share one stimulus:
// u_dut0 uses the default parameters, u_dut1 uses DEBOUNCE = 1 and u_dut2
// uses COUNT_WIDTH = 4.
module tb_cw_detector;

  logic               clk;
  logic               resetn;
  logic               valid_in;
  logic signed [15:0] mag_in;
  logic        [15:0] th_on;
  logic        [15:0] th_off;

  logic signed [15:0] avg0, avg1, avg2;
  logic               key0, key1, key2;
  logic               dv0, dv1, dv2;
  logic               dmark0, dmark1, dmark2;
  logic        [23:0] dur0, dur1;
  logic        [3:0]  dur2;

  int checks;
  int errors;
  int edge_n;
  int first0, first1, first2;
  int dv_cnt0;
  logic [23:0] cap_dur0, cap_dur1;
  logic [3:0]  cap_dur2;
  logic        cap_mark0, cap_mark1;
  logic        key_low_seen, key_high_seen, avg_nz_seen;
  int          rep_dur[$];
  int          rep_mark[$];

  cw_detector #(.DATA_WIDTH(16), .AVG_SHIFT(4), .DEBOUNCE(8), .COUNT_WIDTH(24)) u_dut0 (
    .i_clk(clk), .i_resetn(resetn), .i_valid(valid_in), .iS_magnitude(mag_in),
    .i_thresholdOn(th_on), .i_thresholdOff(th_off), .oS_average(avg0),
    .o_key_n(key0), .o_durationValid(dv0), .o_durationMark(dmark0), .o_duration(dur0));

  cw_detector #(.DATA_WIDTH(16), .AVG_SHIFT(4), .DEBOUNCE(1), .COUNT_WIDTH(24)) u_dut1 (
    .i_clk(clk), .i_resetn(resetn), .i_valid(valid_in), .iS_magnitude(mag_in),
    .i_thresholdOn(th_on), .i_thresholdOff(th_off), .oS_average(avg1),
    .o_key_n(key1), .o_durationValid(dv1), .o_durationMark(dmark1), .o_duration(dur1));

  cw_detector #(.DATA_WIDTH(16), .AVG_SHIFT(4), .DEBOUNCE(8), .COUNT_WIDTH(4)) u_dut2 (
    .i_clk(clk), .i_resetn(resetn), .i_valid(valid_in), .iS_magnitude(mag_in),
    .i_thresholdOn(th_on), .i_thresholdOff(th_off), .oS_average(avg2),
    .o_key_n(key2), .o_durationValid(dv2), .o_durationMark(dmark2), .o_duration(dur2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mag;
    logic        valid;
    logic [15:0] exp_avg;
    logic        exp_key_n;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("check %s actual=%0d required=%0d ok", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    edge_n        = 0;
    first0        = 0;
    first1        = 0;
    first2        = 0;
    dv_cnt0       = 0;
    cap_dur0      = '0;
    cap_dur1      = '0;
    cap_dur2      = '0;
    cap_mark0     = 1'b0;
    cap_mark1     = 1'b0;
    key_low_seen  = 1'b0;
    key_high_seen = 1'b0;
    avg_nz_seen   = 1'b0;
    rep_dur.delete();
    rep_mark.delete();
  endtask

  // Drive one cycle's inputs, clock once, then record observations 1 ns later.
  task automatic step(input logic [15:0] mag, input logic v);
    mag_in   = mag;
    valid_in = v;
    @(posedge clk);
    #1;
    edge_n++;
    if (dv0) begin
      dv_cnt0++;
      rep_dur.push_back(int'(dur0));
      rep_mark.push_back(int'(dmark0));
      if (first0 == 0) begin
        first0    = edge_n;
        cap_dur0  = dur0;
        cap_mark0 = dmark0;
      end
    end
    if (dv1 && first1 == 0) begin
      first1    = edge_n;
      cap_dur1  = dur1;
      cap_mark1 = dmark1;
    end
    if (dv2 && first2 == 0) begin
      first2   = edge_n;
      cap_dur2 = dur2;
    end
    if (key0) key_high_seen = 1'b1;
    else      key_low_seen  = 1'b1;
    if (avg0 != 16'sd0) avg_nz_seen = 1'b1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    valid_in = 1'b0;
    mag_in   = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_mon();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    resetn   = 1'b0;
    valid_in = 1'b0;
    mag_in   = '0;
    th_on    = 16'd16000;
    th_off   = 16'd8000;
    clear_mon();

    // Hand-computed filter response to a constant 32000 from reset, with one
    // idle cycle at the end that must hold the average.
    vecs[0]  = '{16'd32000, 1'b1, 16'd2000,  1'b1};
    vecs[1]  = '{16'd32000, 1'b1, 16'd3875,  1'b1};
    vecs[2]  = '{16'd32000, 1'b1, 16'd5632,  1'b1};
    vecs[3]  = '{16'd32000, 1'b1, 16'd7280,  1'b1};
    vecs[4]  = '{16'd32000, 1'b1, 16'd8825,  1'b1};
    vecs[5]  = '{16'd32000, 1'b1, 16'd10274, 1'b1};
    vecs[6]  = '{16'd32000, 1'b1, 16'd11632, 1'b1};
    vecs[7]  = '{16'd32000, 1'b1, 16'd12905, 1'b1};
    vecs[8]  = '{16'd32000, 1'b1, 16'd14098, 1'b1};
    vecs[9]  = '{16'd32000, 1'b1, 16'd15217, 1'b1};
    vecs[10] = '{16'd32000, 1'b1, 16'd16266, 1'b1};
    vecs[11] = '{16'd0,     1'b0, 16'd16266, 1'b1};

    // ---- reset values, before any clock edge ----
    #3;
    check("rst_avg",   {16'd0, avg0}, 32'd0);
    check("rst_key_n", {31'd0, key0}, 32'd1);
    check("rst_dv",    {31'd0, dv0},  32'd0);
    check("rst_mark",  {31'd0, dmark0}, 32'd0);
    check("rst_dur",   {8'd0, dur0},  32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_mon();

    // ---- rising tone: table-driven filter check ----
    foreach (vecs[i]) begin
      step(vecs[i].mag, vecs[i].valid);
      check($sformatf("vec%0d_avg", i),   {16'd0, avg0}, {16'd0, vecs[i].exp_avg});
      check($sformatf("vec%0d_key_n", i), {31'd0, key0}, {31'd0, vecs[i].exp_key_n});
    end
    // Sample 11 first reaches 16000; eight candidates end at sample 18, whose
    // evaluation edge is edge 20 because of the idle cycle at edge 12.
    for (int i = 0; i < 18; i++) step(16'd32000, 1'b1);
    check("rise_edge",   32'(first0), 32'd20);
    check("rise_dur",    {8'd0, cap_dur0}, 32'd18);
    check("rise_mark",   {31'd0, cap_mark0}, 32'd0);
    check("rise_key_n",  {31'd0, key0}, 32'd0);
    check("rise_dv_cnt", 32'(dv_cnt0), 32'd1);
    check("deb1_edge",   32'(first1), 32'd12);
    check("deb1_dur",    {8'd0, cap_dur1}, 32'd11);
    check("deb1_mark",   {31'd0, cap_mark1}, 32'd0);
    check("sat_edge",    32'(first2), 32'd20);
    check("sat_dur",     {28'd0, cap_dur2}, 32'd15);

    // ---- hysteresis: 12000 sits between the thresholds ----
    for (int i = 0; i < 100; i++) step(16'd32000, 1'b1);
    clear_mon();
    for (int i = 0; i < 300; i++) step(16'd12000, 1'b1);
    check("hyst_key_held", {31'd0, key_high_seen}, 32'd0);
    check("hyst_no_dv",    32'(dv_cnt0), 32'd0);
    clear_mon();
    for (int i = 0; i < 100; i++) step(16'd0, 1'b1);
    check("hyst_key_n",  {31'd0, key0}, 32'd1);
    check("hyst_dv_cnt", 32'(dv_cnt0), 32'd1);
    check("hyst_mark",   {31'd0, cap_mark0}, 32'd1);

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 30; i++) step(16'd32000, 1'b1);
    check("pre_rst_key_n", {31'd0, key0}, 32'd0);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_key_n", {31'd0, key0}, 32'd1);
    check("arst_avg",   {16'd0, avg0}, 32'd0);
    check("arst_dv",    {31'd0, dv0},  32'd0);
    check("arst_dur",   {8'd0, dur0},  32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_mon();
    step(16'd32000, 1'b1);
    check("restart_avg", {16'd0, avg0}, 32'd2000);

    // ---- glitch rejection: only sample 104 (avg 7455) reaches On = 7000 ----
    th_on  = 16'd7000;
    th_off = 16'd3000;
    do_reset();
    for (int i = 0; i < 100; i++) step(16'd0, 1'b1);
    for (int i = 0; i < 4; i++)   step(16'd32767, 1'b1);
    for (int i = 0; i < 60; i++)  step(16'd0, 1'b1);
    check("glitch_no_dv",   32'(dv_cnt0), 32'd0);
    check("glitch_key_low", {31'd0, key_low_seen}, 32'd0);
    check("glitch_deb1_edge", 32'(first1), 32'd105);
    check("glitch_deb1_dur",  {8'd0, cap_dur1}, 32'd104);
    check("glitch_deb1_mark", {31'd0, cap_mark1}, 32'd0);

    // ---- negative clamp ----
    th_on  = 16'd16000;
    th_off = 16'd8000;
    do_reset();
    for (int i = 0; i < 50; i++) step(16'h8000, 1'b1);
    check("clamp_avg_nz",   {31'd0, avg_nz_seen}, 32'd0);
    check("clamp_key_low",  {31'd0, key_low_seen}, 32'd0);
    check("clamp_avg",      {16'd0, avg0}, 32'd0);

    // ---- keying square wave, valid every other cycle ----
    // With On = 24000 and Off = 8000 both edges cross on element sample 22,
    // so every commit lands on element sample 29 and steady elements are 400.
    th_on  = 16'd24000;
    th_off = 16'd8000;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 400; i++) begin
        step(16'd32000, 1'b1);
        step(16'd32000, 1'b0);
      end
      for (int i = 0; i < 400; i++) begin
        step(16'd0, 1'b1);
        step(16'd0, 1'b0);
      end
    end
    check("key_rep_cnt",   32'(rep_dur.size()), 32'd10);
    if (rep_dur.size() > 0) begin
      check("key_rep0_dur",  32'(rep_dur[0]),  32'd29);
      check("key_rep0_mark", 32'(rep_mark[0]), 32'd0);
    end
    for (int k = 2; k < rep_dur.size(); k++) begin
      check($sformatf("key_rep%0d_dur", k),  32'(rep_dur[k]),  32'd400);
      check($sformatf("key_rep%0d_mark", k), 32'(rep_mark[k]), 32'(k % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
